ram_b_arbiter: RTL and testbench
================================

Name: ram_b_arbiter

Overview:
- Round-robin arbiter and sequencer for the frame-buffer RAM's port B (the processor-side port; port A stays with the VGA pixel path).
- Shares port B between NREQ requesters: processor at index 0, image loader/filter engine at index 1.
- Registers the winning access onto the RAM pins.
- Tracks in-flight reads through the RAM's fixed read latency and returns read data to the correct requester with a per-requester valid strobe.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 32, address width, matches the RAM port address bus.
- DW, 8, data width, matches the RAM port data bus.
- RD_LAT, 2, cycles from ram_addr presented to ram_q valid (1..4).

Ports:
- clk  in  1  system clock (50 MHz domain of the RAM).
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held until granted.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- lock  in  NREQ  per-requester burst lock; only effective with ARB_LOCK_EN.
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, combinational; accept = req[i] & gnt[i].
- rvalid  out  NREQ  one-hot read-data strobe, registered.
- rdata  out  DW  read data, registered; broadcast to all requesters, qualified by rvalid.
- ram_addr  out  AW  to RAM address_b.
- ram_wdata  out  DW  to RAM data_b.
- ram_wren  out  1  to RAM wren_b.
- ram_q  in  DW  from RAM q_b.

Behaviour:
- Reset (async assert, sync-free deassert): gnt=0, rvalid=0, rdata=0, ram_addr=0, ram_wdata=0, ram_wren=0, priority pointer=0, lock owner cleared, read tag pipe cleared.
- Grant:
  - gnt is one-hot or zero, combinational from req and the pointer.
  - Search starts at the pointer and wraps modulo NREQ; the first requester with req=1 wins.
  - At most one accept per cycle.
  - Requester must hold addr/we/wdata stable while req=1 and gnt=0.
- Pointer: after each accept by requester k, the pointer becomes (k+1) mod NREQ. With no accept, the pointer holds.
- Issue:
  - The cycle after an accept, ram_addr/ram_wdata take the accepted values and ram_wren equals accepted we, asserted for exactly one cycle.
  - With no accept, ram_wren=0 and ram_addr/ram_wdata hold their last values.
- Read return:
  - An accepted read by k pushes tag {valid=1, id=k} into a pipe of RD_LAT+1 stages.
  - At the pipe output, rdata<=ram_q and rvalid[k]<=1 for one cycle.
  - Total accept-to-rvalid latency is RD_LAT+2 cycles, fully pipelined: back-to-back reads give back-to-back rvalid in order.
  - Writes push tag valid=0.
- Throughput: one access per cycle sustained; no bubbles between requesters.
- Simultaneous requests: the pointer decides. Both requesters requesting continuously alternate 0,1,0,1.
- Read-after-write to the same address from different requesters: RAM port ordering applies; the arbiter does no forwarding.
- Reset mid-operation: in-flight read tags are discarded and no rvalid is generated for them.
- Unused rdata when rvalid=0: holds its last value.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - When requester k is accepted with lock[k]=1, k becomes lock owner.
  - While owner holds lock[k]=1, only k can be granted and the pointer does not rotate.
  - Owner releases on an accepted access with lock[k]=0, or when the owner deasserts req and lock.
  - Max lock length is not limited.
- Undefined: the lock input is ignored (port kept for a stable interface); pure round-robin.

Decomposition:
- Package ram_arb_pkg:
  - default AW/DW/RD_LAT constants;
  - requester index constants REQ_PROC=0, REQ_LOADER=1;
  - read tag typedef {valid, id[clog2(NREQ)]}.
- Sub-module rd_tag_pipe: parameterised RD_LAT+1-stage shift register of tags with async active-low clear; the arbiter top instantiates it once.

Test Plan:
- Single read: req[0]=1, we=0, addr=0x10 with RAM preloaded 0x10=0xA5 -> gnt[0] same cycle; ram_addr=0x10 next cycle; rvalid[0]=1 and rdata=0xA5 at accept+4 (RD_LAT=2).
- Contention: req=2'b11, both reads, held 6 cycles -> grants 0,1,0,1,0,1; rvalid order matches; no gaps.
- Write: req[1]=1, we=1, addr=0x20, wdata=0x3C -> ram_wren high exactly one cycle with ram_addr=0x20 and ram_wdata=0x3C; no rvalid; a later read of 0x20 returns 0x3C.
- Reset mid-flight: 3 back-to-back reads, rst_n low 1 cycle after the third accept -> all outputs 0; no rvalid ever asserted for those reads.
- Idle: req=0 for 10 cycles after a write -> ram_wren=0; ram_addr holds; pointer unchanged, so the next single requester is granted immediately.
- Lock (ARB_LOCK_EN): requester 1 accepted with lock=1 for 4 accesses while req[0]=1 -> gnt[0]=0 throughout; releases on the 4th access with lock=0; requester 0 granted the next cycle.

Source files
------------

// File: rtl/ram_b_arbiter_pkg.sv
// Shared definitions for the frame-buffer RAM port-B arbiter.
// Holds the default bus geometry, the requester index map and the read-tag type.
package ram_arb_pkg;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 8;
    localparam int DEF_RD_LAT = 2;

    localparam int REQ_PROC   = 0;
    localparam int REQ_LOADER = 1;

    // Tag id is sized for the largest supported requester count.
    localparam int NREQ_MAX = 4;
    localparam int ID_W     = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    // Round-robin successor of requester k among n requesters.
    function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] k, input int n);
        if (int'(k) + 1 >= n) begin
            return '0;
        end
        return k + ID_W'(1);
    endfunction

endpackage

// File: rtl/ram_b_arbiter_if.sv
// Requester-side and RAM-side bus bundle of the port-B arbiter.
// master: a requester; slave: the arbiter; ram: the RAM port B model/macro.
interface ram_b_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_wren;
    logic [DW-1:0]      ram_q;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata, ram_q,
        output gnt, rvalid, rdata, ram_addr, ram_wdata, ram_wren
    );

    modport ram (
        input  ram_addr, ram_wdata, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/ram_b_arbiter_rd_tag_pipe.sv
// Delay line carrying read tags alongside the RAM read latency so the
// returning data can be steered to the requester that issued the read.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT + 1
)(
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_b_arbiter.sv
// Round-robin arbiter and sequencer for frame-buffer RAM port B.
// Grants one requester per cycle, registers the access onto the RAM pins and
// returns read data with a per-requester strobe RD_LAT+2 cycles after accept.
// Optional burst locking is compiled in with the macro ARB_LOCK_EN.
module ram_b_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic           clk,
    input  logic           rst_n,
    ram_b_arbiter_if.slave bus
);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_c;
    logic            accept;
    logic [ID_W-1:0] win_id;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic            ram_wren_q, ram_wren_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    rd_tag_t tag_in, tag_out;

`ifdef ARB_LOCK_EN
    logic [NREQ-1:0] owner_mask;
    logic            owner_vld_q, owner_vld_d;
    logic [ID_W-1:0] owner_id_q, owner_id_d;
    logic            win_lock;

    // Decode the current lock owner into a requester mask.
    always_comb begin
        owner_mask = '0;
        for (int j = 0; j < NREQ; j++) begin
            owner_mask[j] = (owner_id_q == ID_W'(j));
        end
    end

    // Ownership is taken by a locked accept and dropped by an unlocked accept
    // or when the owner lets go of both req and lock.
    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_id_d  = owner_id_q;
        if (accept) begin
            owner_vld_d = win_lock;
            owner_id_d  = win_id;
        end else if (owner_vld_q && !(|(bus.req & owner_mask)) && !(|(bus.lock & owner_mask))) begin
            owner_vld_d = 1'b0;
        end
    end

    // Lock ownership register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_vld_q <= 1'b0;
            owner_id_q  <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_id_q  <= owner_id_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Search from the pointer with wrap-around; the first eligible requester wins
    // and its access fields are muxed out alongside the grant.
    always_comb begin
        eligible = bus.req;
`ifdef ARB_LOCK_EN
        if (owner_vld_q) begin
            eligible = bus.req & owner_mask;
        end
        win_lock = 1'b0;
`endif
        gnt_c     = '0;
        accept    = 1'b0;
        win_id    = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int r = 0; r < NREQ; r++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!accept && eligible[j] && (((int'(ptr_q) + r) % NREQ) == j)) begin
                    gnt_c[j]  = 1'b1;
                    accept    = 1'b1;
                    win_id    = ID_W'(j);
                    win_we    = bus.we[j];
                    win_addr  = bus.addr[j*AW +: AW];
                    win_wdata = bus.wdata[j*DW +: DW];
`ifdef ARB_LOCK_EN
                    win_lock  = bus.lock[j];
`endif
                end
            end
        end
    end

    // Next-state for pointer, RAM pins and read return; reads push a valid tag.
    always_comb begin
        ptr_d       = accept ? next_index(win_id, NREQ) : ptr_q;
        ram_addr_d  = accept ? win_addr : ram_addr_q;
        ram_wdata_d = accept ? win_wdata : ram_wdata_q;
        ram_wren_d  = accept & win_we;
        tag_in.valid = accept & ~win_we;
        tag_in.id    = win_id;
        rvalid_d = '0;
        for (int j = 0; j < NREQ; j++) begin
            rvalid_d[j] = tag_out.valid && (tag_out.id == ID_W'(j));
        end
        rdata_d = tag_out.valid ? bus.ram_q : rdata_q;
    end

    // Arbitration pointer, registered RAM access and read-return registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign bus.gnt       = gnt_c;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_ram_b_arbiter.sv
// Directed bench for ram_b_arbiter with a two-cycle-latency RAM model whose
// unwritten contents are addr ^ 8'hB5. Define ARB_LOCK_EN to add the lock test.
module tb_ram_b_arbiter;
    import ram_arb_pkg::*;

    localparam int NREQ   = 2;
    localparam int AW     = 32;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ram_b_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    ram_b_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM port B model: address registered, then output registered.
    logic [7:0] mem [256];
    logic       memReady = 1'b0;
    logic [7:0] addrReg;
    logic [7:0] qReg;

    always @(posedge clk) begin
        if (!memReady) begin
            for (int a = 0; a < 256; a++) begin
                mem[a] <= 8'(a) ^ 8'hB5;
            end
            memReady <= 1'b1;
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
        end
        addrReg <= bus.ram_addr[7:0];
        qReg    <= mem[addrReg];
    end

    assign bus.ram_q = qReg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_gnt got %b exp 00", bus.gnt); end
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_rvalid got %b exp 00", bus.rvalid); end
        vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rdata got %h exp 00", bus.rdata); end
        vectors++; if (bus.ram_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ram_addr got %h exp 0", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_ram_wdata got %h exp 00", bus.ram_wdata); end
        vectors++; if (bus.ram_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_wren got %b exp 0", bus.ram_wren); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        logic [1:0] expRv;
        bus.req = 2'b01;
        bus.we  = 2'b00;
        bus.addr[REQ_PROC*AW +: AW] = 32'h10;
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("[TB] FAIL single_gnt got %b exp 01", bus.gnt); end
        for (int c = 1; c <= 5; c++) begin
            step();
            bus.req = 2'b00;
            if (c == 1) begin
                vectors++; if (bus.ram_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL single_ram_addr got %h exp 10", bus.ram_addr); end
                vectors++; if (bus.ram_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ram_wren got %b exp 0", bus.ram_wren); end
            end
            expRv = (c == 4) ? 2'b01 : 2'b00;
            vectors++; if (bus.rvalid !== expRv) begin miscompares++; $display("[TB] FAIL single_rvalid c=%0d got %b exp %b", c, bus.rvalid, expRv); end
            if (c == 4) begin
                vectors++; if (bus.rdata !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_rdata got %h exp a5", bus.rdata); end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  expG;
        logic [1:0]  expRv;
        logic [7:0]  expD;
        logic [31:0] expA;
        doReset();
        bus.we = 2'b00;
        bus.addr[REQ_PROC*AW +: AW]   = 32'h40;
        bus.addr[REQ_LOADER*AW +: AW] = 32'h41;
        for (int c = 0; c < 12; c++) begin
            bus.req = (c < 6) ? 2'b11 : 2'b00;
            #1;
            if (c < 6) begin
                expG = (c % 2 == 0) ? 2'b01 : 2'b10;
                vectors++; if (bus.gnt !== expG) begin miscompares++; $display("[TB] FAIL cont_gnt c=%0d got %b exp %b", c, bus.gnt, expG); end
            end
            if (c >= 1 && c <= 6) begin
                expA = ((c - 1) % 2 == 0) ? 32'h40 : 32'h41;
                vectors++; if (bus.ram_addr !== expA) begin miscompares++; $display("[TB] FAIL cont_ram_addr c=%0d got %h exp %h", c, bus.ram_addr, expA); end
            end
            if (c >= 4 && c <= 9) begin
                expRv = ((c - 4) % 2 == 0) ? 2'b01 : 2'b10;
                expD  = ((c - 4) % 2 == 0) ? 8'hF5 : 8'hF4;
                vectors++; if (bus.rdata !== expD) begin miscompares++; $display("[TB] FAIL cont_rdata c=%0d got %h exp %h", c, bus.rdata, expD); end
            end else begin
                expRv = 2'b00;
            end
            vectors++; if (bus.rvalid !== expRv) begin miscompares++; $display("[TB] FAIL cont_rvalid c=%0d got %b exp %b", c, bus.rvalid, expRv); end
            step();
        end
    endtask

    task automatic test_write_idle();
        logic [1:0] expRv;
        bus.req = 2'b10;
        bus.we  = 2'b10;
        bus.addr[REQ_LOADER*AW +: AW]  = 32'h20;
        bus.wdata[REQ_LOADER*DW +: DW] = 8'h3C;
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("[TB] FAIL write_gnt got %b exp 10", bus.gnt); end
        step();
        bus.req = 2'b00;
        bus.we  = 2'b00;
        vectors++; if (bus.ram_wren !== 1'b1) begin miscompares++; $display("[TB] FAIL write_wren got %b exp 1", bus.ram_wren); end
        vectors++; if (bus.ram_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL write_addr got %h exp 20", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 8'h3C) begin miscompares++; $display("[TB] FAIL write_wdata got %h exp 3c", bus.ram_wdata); end
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++; if (bus.ram_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_wren c=%0d got %b exp 0", c, bus.ram_wren); end
            vectors++; if (bus.ram_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL idle_addr c=%0d got %h exp 20", c, bus.ram_addr); end
            vectors++; if (bus.ram_wdata !== 8'h3C) begin miscompares++; $display("[TB] FAIL idle_wdata c=%0d got %h exp 3c", c, bus.ram_wdata); end
            vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("[TB] FAIL idle_rvalid c=%0d got %b exp 00", c, bus.rvalid); end
        end
        bus.req = 2'b10;
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("[TB] FAIL raw_gnt got %b exp 10", bus.gnt); end
        for (int c = 1; c <= 5; c++) begin
            step();
            bus.req = 2'b00;
            expRv = (c == 4) ? 2'b10 : 2'b00;
            vectors++; if (bus.rvalid !== expRv) begin miscompares++; $display("[TB] FAIL raw_rvalid c=%0d got %b exp %b", c, bus.rvalid, expRv); end
            if (c == 4) begin
                vectors++; if (bus.rdata !== 8'h3C) begin miscompares++; $display("[TB] FAIL raw_rdata got %h exp 3c", bus.rdata); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bus.we = 2'b00;
        for (int c = 0; c < 3; c++) begin
            bus.req = 2'b01;
            bus.addr[REQ_PROC*AW +: AW] = 32'h50 + 32'(c);
            #1;
            vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("[TB] FAIL mid_gnt c=%0d got %b exp 01", c, bus.gnt); end
            step();
        end
        bus.req = 2'b00;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_rst_rvalid got %b exp 00", bus.rvalid); end
        vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rst_rdata got %h exp 00", bus.rdata); end
        vectors++; if (bus.ram_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_addr got %h exp 0", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rst_wdata got %h exp 00", bus.ram_wdata); end
        vectors++; if (bus.ram_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_wren got %b exp 0", bus.ram_wren); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_after_rvalid c=%0d got %b exp 00", c, bus.rvalid); end
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] expG;
        bus.we = 2'b00;
        bus.addr[REQ_PROC*AW +: AW]   = 32'h60;
        bus.addr[REQ_LOADER*AW +: AW] = 32'h61;
        for (int c = 0; c < 5; c++) begin
            bus.req  = (c == 0) ? 2'b10 : 2'b11;
            bus.lock = (c < 3) ? 2'b10 : 2'b00;
            expG     = (c < 4) ? 2'b10 : 2'b01;
            #1;
            vectors++; if (bus.gnt !== expG) begin miscompares++; $display("[TB] FAIL lock_gnt c=%0d got %b exp %b", c, bus.gnt, expG); end
            step();
        end
        bus.req  = 2'b00;
        bus.lock = 2'b00;
        repeat (6) step();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.we    = '0;
        bus.lock  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_idle();
        test_reset_midflight();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
